// File: rtl/iob_pwm_gen_pkg.sv
// rtl/iob_pwm_gen_pkg.sv - shared state encoding and default widths for the PWM generator
package iob_pwm_gen_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PRESC_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/iob_pwm_gen_if.sv
// rtl/iob_pwm_gen_if.sv - register-side configuration and waveform outputs of the PWM generator
interface iob_pwm_gen_if #(
    parameter int CNT_W   = iob_pwm_gen_pkg::CNT_W_DEF,
    parameter int PRESC_W = iob_pwm_gen_pkg::PRESC_W_DEF
);

    logic               en_i;
    logic [CNT_W-1:0]   period_i;
    logic [CNT_W-1:0]   duty_i;
    logic [PRESC_W-1:0] presc_i;
    logic               pol_i;
    logic               upd_i;
    logic               pwm_o;
    logic               period_end_o;
    logic [CNT_W-1:0]   cnt_o;
    logic               upd_pend_o;

    modport master (
        output en_i, period_i, duty_i, presc_i, pol_i, upd_i,
        input  pwm_o, period_end_o, cnt_o, upd_pend_o
    );

    modport slave (
        input  en_i, period_i, duty_i, presc_i, pol_i, upd_i,
        output pwm_o, period_end_o, cnt_o, upd_pend_o
    );

endinterface

// File: rtl/iob_pwm_presc.sv
// rtl/iob_pwm_presc.sv - prescaler counting 0..div_i, tick in the terminal cycle
module iob_pwm_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt;

    assign tick_o = (cnt == div_i);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iob_pwm_gen.sv
// rtl/iob_pwm_gen.sv - PWM waveform core with period-boundary shadow reload
import iob_pwm_gen_pkg::*;

module iob_pwm_gen #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic         clk,
    input  logic         arst_n,
    iob_pwm_gen_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   duty_sh;
    logic [PRESC_W-1:0] presc_sh;
    logic               pol_sh;
    logic               upd_pend;
    logic               pwm;
    logic               period_end;

    logic               tick;
    logic               presc_clr;
    logic               wrap;
    logic               reload;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   duty_use;
    logic               pol_use;

    // Prescaler restarts from 0 on every entry into RUN and whenever RUN is left
    assign presc_clr = (state == ST_IDLE) || !bus.en_i;

    iob_pwm_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk    (clk),
        .arst_n (arst_n),
        .clr_i  (presc_clr),
        .div_i  (presc_sh),
        .tick_o (tick)
    );

    always_comb begin
        wrap     = tick && (cnt == period_sh);
        reload   = wrap && (upd_pend || bus.upd_i);
        cnt_next = cnt;
        if (tick) begin
            cnt_next = wrap ? '0 : cnt + 1'b1;
        end
        // A reload at the wrap must already shape the first sample of the new period
        duty_use = reload ? bus.duty_i : duty_sh;
        pol_use  = reload ? bus.pol_i  : pol_sh;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            period_sh  <= '0;
            duty_sh    <= '0;
            presc_sh   <= '0;
            pol_sh     <= 1'b0;
            upd_pend   <= 1'b0;
            pwm        <= 1'b0;
            period_end <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt        <= '0;
                    upd_pend   <= 1'b0;
                    period_end <= 1'b0;
                    if (bus.en_i) begin
                        state     <= ST_RUN;
                        period_sh <= bus.period_i;
                        duty_sh   <= bus.duty_i;
                        presc_sh  <= bus.presc_i;
                        pol_sh    <= bus.pol_i;
                        pwm       <= (bus.duty_i != '0) ^ bus.pol_i;
                    end else begin
                        pwm <= bus.pol_i;
                    end
                end
                ST_RUN: begin
                    if (!bus.en_i) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        upd_pend   <= 1'b0;
                        period_end <= 1'b0;
                        pwm        <= bus.pol_i;
                    end else begin
                        cnt        <= cnt_next;
                        period_end <= wrap;
                        pwm        <= (cnt_next < duty_use) ^ pol_use;
                        if (reload) begin
                            period_sh <= bus.period_i;
                            duty_sh   <= bus.duty_i;
                            presc_sh  <= bus.presc_i;
                            pol_sh    <= bus.pol_i;
                            upd_pend  <= 1'b0;
                        end else if (bus.upd_i) begin
                            upd_pend <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pwm_o        = pwm;
    assign bus.period_end_o = period_end;
    assign bus.cnt_o        = cnt;
    assign bus.upd_pend_o   = upd_pend;

endmodule

// File: tb/tb_iob_pwm_gen.sv
// tb/tb_iob_pwm_gen.sv - directed self-checking bench for iob_pwm_gen
module tb_iob_pwm_gen;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    iob_pwm_gen_if bus ();

    iob_pwm_gen dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int d, input int s, input logic pol);
        bus.period_i = 32'(p);
        bus.duty_i   = 32'(d);
        bus.presc_i  = 16'(s);
        bus.pol_i    = pol;
    endtask

    task automatic idle_chk(input string tag, input logic pol);
        chk({tag, " cnt"},  bus.cnt_o,        32'd0);
        chk({tag, " pwm"},  bus.pwm_o,        32'(pol));
        chk({tag, " pend"}, bus.period_end_o, 32'd0);
        chk({tag, " upd"},  bus.upd_pend_o,   32'd0);
    endtask

    // Enables with a fixed configuration and compares n cycles against a closed-form model
    task automatic run_wave(input string tag, input int p, input int d, input int s,
                            input logic pol, input int n);
        int  ec;
        logic ep;
        logic epe;
        set_cfg(p, d, s, pol);
        bus.en_i = 1'b0;
        step();
        chk({tag, " idle level"}, bus.pwm_o, 32'(pol));
        bus.en_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            ec  = (k / (s + 1)) % (p + 1);
            ep  = (ec < d) ^ pol;
            epe = (k > 0) && (k % (s + 1) == 0) && (ec == 0);
            chk($sformatf("%s k=%0d cnt", tag, k), bus.cnt_o, 32'(ec));
            chk($sformatf("%s k=%0d pwm", tag, k), bus.pwm_o, 32'(ep));
            chk($sformatf("%s k=%0d pe", tag, k),  bus.period_end_o, 32'(epe));
        end
        bus.en_i = 1'b0;
        step();
        idle_chk({tag, " off"}, pol);
    endtask

    initial begin
        int ed;
        int ec;
        bus.en_i  = 1'b0;
        bus.upd_i = 1'b0;
        set_cfg(0, 0, 0, 1'b0);

        repeat (3) step();
        idle_chk("reset", 1'b0);
        arst_n = 1'b1;
        step();
        idle_chk("idle", 1'b0);

        run_wave("basic",     9, 3,  0, 1'b0, 30);
        run_wave("presc",     4, 2,  3, 1'b0, 40);
        run_wave("duty0",     9, 0,  0, 1'b0, 20);
        run_wave("duty100",   9, 10, 0, 1'b0, 20);
        run_wave("period0",   0, 1,  0, 1'b0, 10);
        run_wave("basic_n",   9, 3,  0, 1'b1, 20);
        run_wave("duty0_n",   9, 0,  0, 1'b1, 20);
        run_wave("duty100_n", 9, 10, 0, 1'b1, 20);
        run_wave("period0_n", 0, 1,  0, 1'b1, 10);

        // Deferred update (values taken at the wrap), then update coincident with a wrap
        set_cfg(9, 3, 0, 1'b0);
        bus.en_i = 1'b0;
        step();
        bus.en_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            ed = (k < 10) ? 3 : ((k < 20) ? 7 : 2);
            ec = k % 10;
            chk($sformatf("upd k=%0d cnt", k),  bus.cnt_o, 32'(ec));
            chk($sformatf("upd k=%0d pwm", k),  bus.pwm_o, 32'(ec < ed));
            chk($sformatf("upd k=%0d pe", k),   bus.period_end_o, 32'((k > 0) && (ec == 0)));
            chk($sformatf("upd k=%0d pend", k), bus.upd_pend_o, 32'((k >= 6) && (k <= 9)));
            case (k)
                5:  begin bus.duty_i = 32'd5; bus.upd_i = 1'b1; end
                6:  bus.upd_i = 1'b0;
                7:  bus.duty_i = 32'd7;
                8:  bus.upd_i = 1'b1;
                9:  bus.upd_i = 1'b0;
                19: begin bus.duty_i = 32'd2; bus.upd_i = 1'b1; end
                20: bus.upd_i = 1'b0;
                default: ;
            endcase
        end
        bus.en_i = 1'b0;
        step();
        idle_chk("upd off", 1'b0);

        // Enable drop at cnt=6 with an update pending, then restart with new duty
        set_cfg(9, 3, 0, 1'b0);
        bus.en_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 5) bus.upd_i = 1'b1;
            if (k == 6) bus.upd_i = 1'b0;
        end
        chk("abort pre cnt",  bus.cnt_o, 32'd6);
        chk("abort pre pend", bus.upd_pend_o, 32'd1);
        bus.en_i = 1'b0;
        step();
        idle_chk("abort", 1'b0);
        run_wave("restart", 9, 5, 0, 1'b0, 12);

        // Asynchronous reset in the middle of a period
        set_cfg(9, 3, 0, 1'b0);
        bus.en_i = 1'b1;
        step();
        bus.upd_i = 1'b1;
        step();
        bus.upd_i = 1'b0;
        step();
        chk("arst pre cnt",  bus.cnt_o, 32'd2);
        chk("arst pre pwm",  bus.pwm_o, 32'd1);
        chk("arst pre pend", bus.upd_pend_o, 32'd1);
        #2 arst_n = 1'b0;
        #1;
        idle_chk("arst", 1'b0);
        bus.en_i = 1'b0;
        step();
        arst_n = 1'b1;
        step();
        idle_chk("arst release", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
